uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver for the risc8 SoC; it is the receive-side counterpart of the SoC serial transmitter.
- Samples the pad-level serial_rx line, reassembles bytes LSB-first and presents them on a single-entry valid/ready holding register.
- Flags framing errors and overruns.
- Sits between the top-level serial_rx pin and the SoC's memory-mapped UART data/status registers.

Parameters:
- DIVISOR, 52, clk cycles per bit (6 MHz clk / 115200 baud); legal range 4..65535.
- CW, 16, width of the bit-timing counter; must satisfy 2^CW > DIVISOR.

Ports:
- clk  input  1  system clock (6 MHz in the ice40 build).
- reset  input  1  synchronous, active-high reset.
- serial_rx  input  1  asynchronous line input; idle high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  holding register contains an unread byte.
- ready  input  1  consumer accepts data on a cycle where valid&ready.
- framing_error  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  sticky; a completed byte was dropped because the holding register was full.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Synchronizer:
  - Two-flop synchronizer on serial_rx; both flops reset to 1.
  - All decisions use the second flop (rx_s); input-to-detection latency is 2 cycles.
- Reset:
  - Values after reset: data=0, valid=0, framing_error=0, overrun=0, busy=0, counter=0, state=WAIT_IDLE.
  - Reset asserted mid-frame aborts the frame with no output.
- State machine (counter counts down; a "tick" is the cycle the counter reaches 0):
  - WAIT_IDLE: go to IDLE once rx_s=1. Prevents mid-frame resync after reset or a break.
  - IDLE: on rx_s=0, load counter=DIVISOR/2-1 (floor), set busy, go to START.
  - START: on tick, if rx_s=0 load DIVISOR-1, bit index=0, go to DATA. If rx_s=1 (glitch), busy=0 and go to IDLE.
  - DATA: on tick, shift rx_s into shift[7] (right shift, LSB-first) and load DIVISOR-1. After the 8th bit go to STOP.
  - STOP, on tick with rx_s=1:
    - valid=0 or ready=1 that cycle: load data<=shift, valid=1.
    - Otherwise: keep the old data, set overrun.
    - Then go to IDLE, busy=0.
  - STOP, on tick with rx_s=0: framing_error=1 for exactly that cycle, byte discarded, valid/data unchanged, go to WAIT_IDLE (busy stays 1 until line returns high).
- Timing:
  - Sample points are mid-bit: start-bit detection + DIVISOR/2 + k*DIVISOR cycles, k=0..9.
  - valid rises on the cycle after the stop-bit sample.
- Handshake:
  - valid&ready in a cycle with no completion: valid<=0 next cycle, and overrun<=0.
  - Accept and completion in the same cycle: new byte loaded, valid stays 1, overrun not set (cleared if set).
- Back-to-back frames: a start bit arriving immediately after the stop sample point (half a bit later) must be caught. IDLE is re-entered on the cycle after the stop sample.
- Line held low (break): produces one framing_error, then no further activity until the line goes high.

Test Plan:
- Directed frame: DIVISOR=52, reset, line idle; send 0xA5 at 115200.
  - valid=1, data=0xA5 exactly 2+26+9*52+1 cycles after the start falling edge.
  - framing_error=0, overrun=0.
- Back-to-back stream: send 0x00, 0xFF, 0x55 with no idle gap; ready pulsed on each valid.
  - Three bytes in order, no framing_error/overrun.
- Overrun: send 0x11 then 0x22 with ready=0.
  - data stays 0x11 and overrun=1.
  - Asserting ready for one cycle clears valid and overrun.
  - A third byte 0x33 then arrives cleanly.
- Simultaneous accept and completion: second byte's stop-sample cycle coincides with ready=1.
  - data becomes the new byte, valid stays 1, overrun stays 0.
- Glitch and framing:
  - 10-cycle low pulse on idle line -> no valid, busy returns to 0 by cycle 26.
  - Frame 0x3C with stop bit low -> single-cycle framing_error, no valid.
  - Line held low 30 bit-times -> exactly one framing_error, then a normal 0x3C is received after the line goes high.
- Reset mid-frame: assert reset during data bit 4 of 0x96.
  - All outputs 0.
  - Remaining low bits of the aborted frame produce no output.
  - The next full frame 0x96 after line idle is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx: 8N1 asynchronous serial receiver.
//
// Samples the pad-level serial_rx line through a two-flop synchronizer,
// detects the start bit, samples each bit at its midpoint and reassembles
// bytes LSB-first into a single-entry holding register.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   serial_rx      in   asynchronous serial line, idle high
//   data[7:0]      out  received byte, stable while valid=1
//   valid          out  holding register contains an unread byte
//   ready          in   consumer accepts data on a cycle where valid&ready
//   framing_error  out  one-cycle pulse when the stop bit samples low
//   overrun        out  sticky: a completed byte was dropped (register full)
//   busy           out  high from start-bit detection until return to IDLE
//
// Handshake: data is transferred on every rising clock edge where
// valid=1 and ready=1. valid stays high and data stays stable until that
// transfer happens. A byte completing in the same cycle as a transfer
// replaces the accepted one, so valid stays high and overrun is cleared.
//
// The FSM state is held in state_q (type state_e) so it can be probed
// hierarchically.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned DIVISOR = 52,  // clk cycles per bit, 4..65535
  parameter int unsigned CW      = 16   // bit-timing counter width, 2^CW > DIVISOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_e;

  // Start-bit wait is half a bit so every later sample lands mid-bit.
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIVISOR - 1);

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          accept;

  assign tick   = (cnt_q == '0);
  assign accept = valid_q & ready;

  always_comb begin
    state_d   = state_q;
    sync1_d   = serial_rx;
    rx_s_d    = sync1_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    overrun_d = overrun_q;
    busy_d    = busy_q;

    // A transfer empties the holding register; a completion below may refill it.
    if (accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      // Only leave once the line is seen high, so a reset or break in the
      // middle of a frame cannot resync on a data bit.
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_LOAD;
          busy_d  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (!rx_s_q) begin
            cnt_d     = BIT_LOAD;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = BIT_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            if (!valid_q || ready) begin
              data_d    = shift_q;
              valid_d   = 1'b1;
              overrun_d = 1'b0;
            end else begin
              overrun_d = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // Bad stop bit: drop the byte and stay busy until the line idles.
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx: self-checking bench for uart_rx (DIVISOR=52).
// Serial frames are driven on the falling clock edge, outputs are sampled on
// the falling clock edge. A small frame-level model tracks what the holding
// register, overrun flag and framing-error count should be.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DIV = 52;

  // ---- clock / reset -------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       serial_rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.DIVISOR(DIV), .CW(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_rx     (serial_rx),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  // ---- scoreboard / model state ------------------------------------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         fe_seen  = 0;   // number of cycles framing_error was observed high
  logic [7:0] exp_q[$];       // bytes the consumer should read, in order
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_overrun;
  int         m_fe;

  always @(negedge clk) begin
    if (framing_error === 1'b1) fe_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model -----------------------------------------------------
  function automatic void model_reset();
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_overrun = 1'b0;
  endfunction

  function automatic void model_accept();
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endfunction

  // One complete frame: stop_ok says whether the stop bit was high,
  // accept says whether the consumer took the old byte in the completion cycle.
  function automatic void model_frame(input logic [7:0] b, input logic stop_ok,
                                      input logic accept);
    if (!stop_ok) begin
      m_fe++;
      if (accept) model_accept();
    end else if (!m_valid || accept) begin
      m_data    = b;
      m_valid   = 1'b1;
      m_overrun = 1'b0;
      exp_q.push_back(b);
    end else begin
      m_overrun = 1'b1;
    end
  endfunction

  // ---- checking ------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/valid"}, 32'(valid), 32'(m_valid));
    if (m_valid) check({tag, "/data"}, 32'(data), 32'(m_data));
    check({tag, "/overrun"}, 32'(overrun), 32'(m_overrun));
    check({tag, "/fe_count"}, 32'(fe_seen), 32'(m_fe));
  endtask

  // ---- drivers -------------------------------------------------------------
  // Call at a falling edge; drives start, 8 data bits LSB-first, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_rx = f[i];
      repeat (DIV) @(negedge clk);
    end
    serial_rx = 1'b1;
  endtask

  // Waits (bounded) for valid, compares against the scoreboard, pulses ready.
  task automatic read_byte(input string tag);
    int         n;
    logic [7:0] e;
    n = 0;
    while (valid !== 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/valid_seen"}, 32'(valid), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
    check({tag, "/data"}, 32'(data), 32'(e));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    model_accept();
  endtask

  // ---- directed sequence -----------------------------------------------------
  initial begin
    logic [7:0] bb[3];
    logic [7:0] b;
    logic [7:0] y;
    int         gap;

    reset     = 1'b1;
    serial_rx = 1'b1;
    ready     = 1'b0;
    m_fe      = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset/data", 32'(data), 32'h0);
    check("reset/valid", 32'(valid), 32'h0);
    check("reset/fe", 32'(framing_error), 32'h0);
    check("reset/overrun", 32'(overrun), 32'h0);
    check("reset/busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_model("idle");

    // Directed 0xA5: valid must rise exactly 497 cycles after the falling edge.
    fork
      send_frame(8'hA5, 1'b1);
    join_none
    repeat (496) @(negedge clk);
    check("a5/valid_early", 32'(valid), 32'd0);
    check("a5/busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("a5/valid_on_time", 32'(valid), 32'd1);
    check("a5/data", 32'(data), 32'hA5);
    check("a5/busy_done", 32'(busy), 32'd0);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_model("a5");
    repeat (30) @(negedge clk);
    read_byte("a5_read");
    check_model("a5_after_read");

    // Back-to-back stream, no idle gap.
    bb[0] = 8'h00;
    bb[1] = 8'hFF;
    bb[2] = 8'h55;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
      end
    join_none
    for (int i = 0; i < 3; i++) begin
      model_frame(bb[i], 1'b1, 1'b0);
      read_byte("b2b");
    end
    repeat (60) @(negedge clk);
    check_model("b2b_end");

    // Overrun: two bytes with ready low, the second is dropped.
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    check_model("overrun");
    read_byte("overrun_read");
    check_model("overrun_cleared");
    send_frame(8'h33, 1'b1);
    model_frame(8'h33, 1'b1, 1'b0);
    read_byte("overrun_next");

    // Accept in the same cycle the next byte completes.
    send_frame(8'h44, 1'b1);
    model_frame(8'h44, 1'b1, 1'b0);
    y = 8'($urandom_range(0, 255));
    fork
      send_frame(y, 1'b1);
    join_none
    repeat (496) @(negedge clk);
    check_model("simul_pre");
    ready = 1'b1;
    check("simul/old_data", 32'(data), 32'(exp_q.pop_front()));
    @(negedge clk);
    ready = 1'b0;
    model_frame(y, 1'b1, 1'b1);
    check_model("simul");
    repeat (30) @(negedge clk);
    read_byte("simul_read");

    // Short glitch on the idle line.
    serial_rx = 1'b0;
    repeat (10) @(negedge clk);
    serial_rx = 1'b1;
    check("glitch/busy_set", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    check("glitch/busy_clear", 32'(busy), 32'd0);
    check_model("glitch");

    // Bad stop bit.
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    model_frame(8'h3C, 1'b0, 1'b0);
    check_model("framing");
    check("framing/busy", 32'(busy), 32'd0);

    // Break: line low for 30 bit-times gives exactly one framing error.
    serial_rx = 1'b0;
    repeat (30 * DIV) @(negedge clk);
    model_frame(8'h00, 1'b0, 1'b0);
    check("break/fe_count", 32'(fe_seen), 32'(m_fe));
    check("break/busy_held", 32'(busy), 32'd1);
    serial_rx = 1'b1;
    repeat (20) @(negedge clk);
    check_model("break_end");
    check("break/busy_clear", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b0);
    read_byte("break_recover");

    // Reset in the middle of data bit 4 of 0x96, held over the low bits 5 and 6.
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    model_frame(b, 1'b1, 1'b0);
    check_model("pre_reset");
    fork
      send_frame(8'h96, 1'b1);
    join_none
    repeat (286) @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    check("midreset/data", 32'(data), 32'h0);
    check("midreset/valid", 32'(valid), 32'h0);
    check("midreset/fe", 32'(framing_error), 32'h0);
    check("midreset/overrun", 32'(overrun), 32'h0);
    check("midreset/busy", 32'(busy), 32'h0);
    model_reset();
    exp_q.delete();
    repeat (116) @(negedge clk);
    reset = 1'b0;
    repeat (164) @(negedge clk);
    check_model("after_reset");
    check("after_reset/busy", 32'(busy), 32'd0);
    send_frame(8'h96, 1'b1);
    model_frame(8'h96, 1'b1, 1'b0);
    read_byte("reset_recover");

    // Random bytes with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 40);
      send_frame(b, 1'b1);
      model_frame(b, 1'b1, 1'b0);
      read_byte("random");
      repeat (gap) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check_model("final");
    check("final/queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
